pps_counter: RTL and testbench
==============================

PPS_COUNTER -- requirements
Module: pps_counter

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, the capture counter and output width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for pps_in and pll_locked (minimum 2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 12000000, the missing-PPS threshold in clock cycles.
REQ-004 SHALL have port clock, input, 1 bit: the PLL global-buffered output clock; the only clock.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pll_locked, input, 1 bit: PLL lock, asynchronous to clock.
REQ-007 SHALL have port pps_in, input, 1 bit: GPS PPS, asynchronous to clock.
REQ-008 SHALL have port count_ready, input, 1 bit: consumer accepts the sample.
REQ-009 SHALL have port count_valid, output, 1 bit: count_data holds a sample.
REQ-010 SHALL have port count_data, output, COUNT_W bits: clock cycles between consecutive PPS rising edges.
REQ-011 SHALL have port count_overrun, output, 1 bit: at least one sample was dropped since the last transfer.
REQ-012 SHALL have port pps_timeout, output, 1 bit: PPS missing.

Function
REQ-013 SHALL synchronize pps_in and pll_locked through SYNC_STAGES flops each, then detect pps rising edges with one history flop.
REQ-014 SHALL use states IDLE, ARM and COUNT.
REQ-015 IDLE: counter held at 0; move to ARM when synchronized lock = 1.
REQ-016 ARM: on a pps edge, load the counter with 1 and move to COUNT; no capture.
REQ-017 COUNT: increment the counter each cycle, saturating at 2^COUNT_W-1.
REQ-018 COUNT: on a pps edge, capture the counter value into the output register and reload 1, so a period of N cycles yields N.
REQ-019 Synchronized lock = 0 in any state SHALL force IDLE and discard the count in progress; any pending output sample is kept.
REQ-020 Latency from the first clock edge that samples pps_in high to count_valid high SHALL be exactly SYNC_STAGES+1 edges.
REQ-021 A transfer SHALL occur on a cycle with count_valid=1 and count_ready=1; count_valid and count_data stay stable until then.
REQ-022 A capture while valid=1 and ready=0 SHALL overwrite count_data with the new value and set count_overrun.
REQ-023 A capture in the same cycle as a transfer SHALL load the new sample, keep valid=1 and clear count_overrun.
REQ-024 A transfer with no simultaneous capture SHALL clear count_valid and count_overrun.

Reset
REQ-025 reset_n low SHALL asynchronously force: state IDLE; counter 0; count_valid, count_data, count_overrun and pps_timeout 0.
REQ-026 reset_n low SHALL asynchronously force the pps synchronizer and history flops to 1, so pps held high through reset produces no edge.
REQ-027 The lock synchronizer SHALL reset to 0.

Configuration
REQ-028 Macro PPS_COUNTER_TIMEOUT_EN, when defined: in COUNT, a counter value reaching TIMEOUT_CYCLES with no edge SHALL set pps_timeout and move to ARM.
REQ-029 With PPS_COUNTER_TIMEOUT_EN defined, pps_timeout SHALL clear on the next pps edge.
REQ-030 Without PPS_COUNTER_TIMEOUT_EN, pps_timeout SHALL be tied 0 and the counter only saturates.

Structure
REQ-031 Package pps_counter_pkg SHALL hold the state enumeration and the default values for COUNT_W, SYNC_STAGES and TIMEOUT_CYCLES.
REQ-032 Sub-module pps_sync SHALL implement the parameterized synchronizer plus rising-edge detector, instantiated for pps_in (edge output used) and for pll_locked (level output used).

Verification
REQ-033 Lock up, PPS period 50 cycles, ready=1 -> first edge gives no sample; every later edge gives count_data=50, valid for one cycle, SYNC_STAGES+1 edges after sampling.
REQ-034 Ready held 0 across three edges, period 40 -> valid stays 1, data=40, overrun=1; then ready=1 for one cycle -> valid=0, overrun=0.
REQ-035 Capture and transfer in the same cycle -> valid remains 1, new data presented, overrun=0.
REQ-036 Drop lock mid-period for 10 cycles, then restore -> no sample for that period; pending sample retained; ARM then resumes correct counts.
REQ-037 PPS_COUNTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, PPS stopped -> pps_timeout=1 at counter value 100; next edge gives no sample and clears pps_timeout; the following period of 60 gives 60.
REQ-038 COUNT_W=8, macro undefined, period 300 -> count_data=255.

Source files
------------

// File: rtl/pps_counter_pkg.sv
// Shared definitions for pps_counter: FSM state encoding and parameter defaults.
package pps_counter_pkg;

    localparam int DEF_COUNT_W        = 32;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 12000000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ARM   = 2'd1;
    localparam state_t ST_COUNT = 2'd2;

endpackage

// File: rtl/pps_counter_sync.sv
// pps_sync: multi-flop synchronizer for an asynchronous level, plus a one-flop rising-edge detector.
module pps_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Reset value also seeds the history flop so a level held through reset is not seen as an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pps_counter.sv
// pps_counter: counts clock cycles between GPS PPS rising edges and offers each period on a valid/ready port.
// Define PPS_COUNTER_TIMEOUT_EN to flag a missing PPS after TIMEOUT_CYCLES and re-arm.
module pps_counter
    import pps_counter_pkg::*;
#(
    parameter int COUNT_W        = DEF_COUNT_W,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               pps_in,
    input  logic               count_ready,
    output logic               count_valid,
    output logic [COUNT_W-1:0] count_data,
    output logic               count_overrun,
    output logic               pps_timeout
);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               pps_edge, lock, capture;
    logic               unused_pps_lvl, unused_lock_rise;

    pps_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_pps_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .async_i (pps_in),
        .level_o (unused_pps_lvl),
        .rise_o  (pps_edge)
    );

    pps_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .async_i (pll_locked),
        .level_o (lock),
        .rise_o  (unused_lock_rise)
    );

`ifdef PPS_COUNTER_TIMEOUT_EN
    localparam logic [COUNT_W-1:0] TIMEOUT_VAL = COUNT_W'(TIMEOUT_CYCLES);
    logic timeout_q, timeout_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
`ifdef PPS_COUNTER_TIMEOUT_EN
        timeout_d = pps_edge ? 1'b0 : timeout_q;
`endif
        // Losing lock abandons the period in progress; the output register is left alone.
        if (!lock) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (pps_edge) begin
                        cnt_d   = COUNT_W'(1);
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (pps_edge) begin
                        capture = 1'b1;
                        cnt_d   = COUNT_W'(1);
                    end
`ifdef PPS_COUNTER_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        state_d   = ST_ARM;
                        cnt_d     = '0;
                    end
`endif
                    else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A capture always wins; it only counts as an overrun if the old sample is not leaving this cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (capture) begin
            valid_d = 1'b1;
            data_d  = cnt_q;
            ovr_d   = valid_q & ~count_ready;
        end else if (valid_q && count_ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef PPS_COUNTER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) timeout_q <= 1'b0;
        else          timeout_q <= timeout_d;
    end
    assign pps_timeout = timeout_q;
`else
    assign pps_timeout = 1'b0;
`endif

    assign count_valid   = valid_q;
    assign count_data    = data_q;
    assign count_overrun = ovr_q;

endmodule

// File: tb/tb_pps_counter.sv
// Self-checking bench for pps_counter: table of PPS periods fed through a scoreboard, plus hand-built corner sequences.
module tb_pps_counter;

    typedef struct {
        int period;
        int exp;
    } vec_t;

    localparam int NV = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pll_locked = 1'b0;
    logic        pps_in = 1'b0;
    logic        count_ready = 1'b0;
    logic        count_valid, count_overrun, pps_timeout;
    logic [31:0] count_data;
    logic        v8, o8, t8;
    logic [7:0]  d8;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int last_edge = 0;
    int mon_exp;
    int sb[$];
    vec_t vecs[NV];

    pps_counter #(.COUNT_W(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pps_in        (pps_in),
        .count_ready   (count_ready),
        .count_valid   (count_valid),
        .count_data    (count_data),
        .count_overrun (count_overrun),
        .pps_timeout   (pps_timeout)
    );

    pps_counter #(.COUNT_W(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(200)) dut8 (
        .clock         (clock),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pps_in        (pps_in),
        .count_ready   (count_ready),
        .count_valid   (v8),
        .count_data    (d8),
        .count_overrun (o8),
        .pps_timeout   (t8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every transfer on the wide DUT must match the oldest expected sample.
    always @(negedge clock) begin
        if (reset_n && count_valid && count_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got data %0d, expected no sample", count_data);
            end else begin
                mon_exp = sb.pop_front();
                check("sample_data", 64'(count_data), 64'(mon_exp));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pps_edge(output int per);
        per       = cyc_cnt - last_edge;
        last_edge = cyc_cnt;
        pps_in    = 1'b1;
        cyc(1);
        pps_in    = 1'b0;
    endtask

    task automatic pulse(input int p, input bit push_it);
        int per;
        pps_edge(per);
        if (push_it) sb.push_back(per);
        if (p > 1) cyc(p - 1);
    endtask

    initial begin
        int per, pend;
        vecs[0] = '{50, 50};
        vecs[1] = '{50, 50};
        vecs[2] = '{50, 50};
        vecs[3] = '{7, 7};
        vecs[4] = '{2, 2};
        vecs[5] = '{97, 97};
        vecs[6] = '{64, 64};
        vecs[7] = '{31, 31};

        // pps held high through reset must not look like an edge
        pps_in      = 1'b1;
        pll_locked  = 1'b1;
        count_ready = 1'b1;
        #23;
        check("rst_valid", 64'(count_valid), 0);
        check("rst_data", 64'(count_data), 0);
        check("rst_overrun", 64'(count_overrun), 0);
        check("rst_timeout", 64'(pps_timeout), 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        cyc(8);
        pps_in = 1'b0;
        cyc(5);

        // Table: first edge arms, each later edge closes vecs[i].period
        pulse(vecs[0].period, 1'b0);
        for (int i = 0; i < NV; i++) begin
            sb.push_back(vecs[i].exp);
            pulse((i < NV - 1) ? vecs[i + 1].period : 20, 1'b0);
        end
        check("table_drain", 64'(sb.size()), 0);

        // Latency: sample taken at edge 1, valid after edge SYNC_STAGES+1, gone after one cycle
        pps_edge(per);
        sb.push_back(per);
        @(negedge clock) check("lat_e1_valid", 64'(count_valid), 0);
        cyc(1);
        @(negedge clock) check("lat_e2_valid", 64'(count_valid), 0);
        cyc(1);
        @(negedge clock) begin
            check("lat_e3_valid", 64'(count_valid), 1);
            check("lat_e3_data", 64'(count_data), 20);
        end
        cyc(1);
        @(negedge clock) check("lat_one_cycle", 64'(count_valid), 0);
        cyc(10);

        // Overrun: three captures with ready low
        count_ready = 1'b0;
        pulse(40, 1'b0);
        pulse(40, 1'b0);
        pulse(40, 1'b0);
        @(negedge clock) begin
            check("ovr_valid", 64'(count_valid), 1);
            check("ovr_data", 64'(count_data), 40);
            check("ovr_flag", 64'(count_overrun), 1);
        end
        cyc(1);
        sb.push_back(40);
        count_ready = 1'b1;
        cyc(1);
        count_ready = 1'b0;
        @(negedge clock) begin
            check("ovr_xfer_valid", 64'(count_valid), 0);
            check("ovr_xfer_flag", 64'(count_overrun), 0);
        end
        cyc(1);

        // Capture and transfer in the same cycle
        pulse(25, 1'b0);
        pulse(33, 1'b0);
        @(negedge clock) check("sc_pre_overrun", 64'(count_overrun), 1);
        pps_edge(per);
        cyc(1);
        count_ready = 1'b1;
        sb.push_back(25);
        cyc(1);
        count_ready = 1'b0;
        @(negedge clock) begin
            check("sc_valid", 64'(count_valid), 1);
            check("sc_data", 64'(count_data), 33);
            check("sc_overrun", 64'(count_overrun), 0);
        end
        cyc(1);
        sb.push_back(33);
        count_ready = 1'b1;
        cyc(1);
        count_ready = 1'b0;
        @(negedge clock) check("sc_xfer_valid", 64'(count_valid), 0);
        cyc(1);

        // Lock drop mid-period: pending sample kept, interrupted period discarded
        pps_edge(pend);
        cyc(19);
        pll_locked = 1'b0;
        cyc(10);
        pll_locked = 1'b1;
        cyc(10);
        @(negedge clock) begin
            check("lk_valid", 64'(count_valid), 1);
            check("lk_data", 64'(count_data), 64'(pend));
            check("lk_overrun", 64'(count_overrun), 0);
        end
        cyc(1);
        sb.push_back(pend);
        count_ready = 1'b1;
        cyc(2);
        pulse(52, 1'b0);
        sb.push_back(52);
        pulse(15, 1'b0);
        check("lk_drain", 64'(sb.size()), 0);

`ifdef PPS_COUNTER_TIMEOUT_EN
        pps_edge(per);
        sb.push_back(per);
        cyc(101);
        @(negedge clock) check("to_before", 64'(pps_timeout), 0);
        cyc(1);
        @(negedge clock) check("to_set", 64'(pps_timeout), 1);
        cyc(20);
        pps_edge(per);
        cyc(2);
        @(negedge clock) check("to_clear", 64'(pps_timeout), 0);
        cyc(57);
        sb.push_back(60);
        pulse(10, 1'b0);
        check("to_drain", 64'(sb.size()), 0);
`else
        check("to_tied", 64'(pps_timeout), 0);
        pulse(300, 1'b1);
        pps_edge(per);
        sb.push_back(per);
        cyc(5);
        check("sat_data8", 64'(d8), 255);
        check("sat_drain", 64'(sb.size()), 0);
`endif

        // Asynchronous reset with a sample pending, no clock edge involved
        count_ready = 1'b0;
        pulse(30, 1'b0);
        @(negedge clock) check("pre_rst_valid", 64'(count_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(count_valid), 0);
        check("arst_data", 64'(count_data), 0);
        check("arst_overrun", 64'(count_overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
